ram_requester: RTL and testbench



---
 rtl/ram_requester.sv | 129 ++++++++++++
 tb/tb_ram_requester.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_requester.sv
// ram_requester: CPU-side initiator for the SRAM driver. It turns single-word requests into strobe/ack
// handshakes, performs read-modify-write for partial writes, and aborts requests that are never acknowledged.
module ram_requester #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [20:0] cpu_addr_i,
  input  logic [3:0]  cpu_be_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_done_o,
  output logic        cpu_err_o,
  output logic        cpu_busy_o,
  output logic        mem_enable_o,
  output logic        mem_read_enable_o,
  output logic        mem_write_enable_o,
  output logic [20:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, RD_STB, RD_WAIT, MERGE, WR_STB, WR_WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic rmw_q, rmw_d, err_d;
  logic [3:0] be_q, be_d;
  logic [20:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rd_q, rd_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic done_q, err_q, busy_q, en_q, re_q, we_q;
  assign cnt_inc = cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    rmw_d = rmw_q;
    be_d = be_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rd_d = rd_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (cpu_req_i) begin
        addr_d = cpu_addr_i;
        wdata_d = cpu_wdata_i;
        be_d = cpu_be_i;
        rdata_d = '0;
        rmw_d = cpu_we_i && cpu_be_i != 4'hf && cpu_be_i != 4'h0;
        state_d = (!cpu_we_i || rmw_d) ? RD_STB : (cpu_be_i == 4'hf) ? WR_STB : DONE;
      end
      RD_STB: begin
        state_d = RD_WAIT;
        cnt_d = '0;
      end
      RD_WAIT: if (mem_ack_i) begin
        rd_d = mem_rdata_i;
        rdata_d = rmw_q ? rdata_q : mem_rdata_i;
        state_d = rmw_q ? MERGE : DONE;
      end else if (cnt_inc == LIMIT) begin
        state_d = DONE;
        err_d = 1'b1;
        rdata_d = '0;
      end else cnt_d = cnt_inc;
      // wdata_q still holds the CPU write data here; only enabled bytes survive the merge
      MERGE: begin
        for (int i = 0; i < 4; i++) wdata_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : rd_q[8*i +: 8];
        state_d = WR_STB;
      end
      WR_STB: begin
        state_d = WR_WAIT;
        cnt_d = '0;
      end
      WR_WAIT: if (mem_ack_i) state_d = DONE;
      else if (cnt_inc == LIMIT) begin
        state_d = DONE;
        err_d = 1'b1;
        rdata_d = '0;
      end else cnt_d = cnt_inc;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rmw_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      en_q <= 1'b0;
      re_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rmw_q <= rmw_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      done_q <= state_d == DONE;
      err_q <= err_d;
      busy_q <= state_d != IDLE;
      en_q <= state_d inside {RD_STB, RD_WAIT, WR_STB, WR_WAIT};
      re_q <= state_d == RD_STB;
      we_q <= state_d == WR_STB;
    end
  end
  assign cpu_rdata_o = rdata_q;
  assign cpu_done_o = done_q;
  assign cpu_err_o = err_q;
  assign cpu_busy_o = busy_q;
  assign mem_enable_o = en_q;
  assign mem_read_enable_o = re_q;
  assign mem_write_enable_o = we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_ram_requester.sv
// tb_ram_requester: checks ram_requester against a word-memory driver model and a transaction-level
// reference model of latency, strobe counts, error status and memory contents.
module tb_ram_requester;
  localparam int T = 15;
  logic clk = 1'b0, rst = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [20:0] cpu_addr = '0;
  logic [3:0] cpu_be = '0;
  logic [31:0] cpu_wdata = '0, mem_rdata = '0;
  logic drv_ack = 1'b0, stray_ack = 1'b0, mem_ack;
  logic [31:0] cpu_rdata, mem_wdata;
  logic cpu_done, cpu_err, cpu_busy, mem_en, mem_re, mem_we;
  logic [20:0] mem_addr;
  int n_assert = 0, n_fail = 0, cyc = 0;
  int lat_cfg = 4, pend = 0, rd_strobes = 0, wr_strobes = 0, done_cnt = 0, done_cyc = 0;
  bit noack = 0, pend_we = 0;
  logic [20:0] wr_addr = '0, ack_addr = '0;
  logic [31:0] wr_data = '0, done_rdata = '0;
  logic done_err = 1'b0;
  logic [31:0] mem [logic [20:0]];
  logic [31:0] ref_mem [logic [20:0]];
  assign mem_ack = drv_ack | stray_ack;
  ram_requester #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_be_i(cpu_be), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_done_o(cpu_done),
    .cpu_err_o(cpu_err), .cpu_busy_o(cpu_busy), .mem_enable_o(mem_en), .mem_read_enable_o(mem_re),
    .mem_write_enable_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack));
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] dflt(input logic [20:0] a);
    return {a[10:0], a};
  endfunction
  function automatic logic [31:0] dev_rd(input logic [20:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? w[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
  // Driver model: acks lat_cfg cycles after each strobe; writes commit on the ack.
  always @(negedge clk) begin
    drv_ack = 1'b0;
    mem_rdata = '0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drv_ack = 1'b1;
        ack_addr = mem_addr;
        if (pend_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = dev_rd(mem_addr);
      end
    end
    if (mem_re === 1'b1 || mem_we === 1'b1) begin
      if (mem_re === 1'b1) rd_strobes++;
      else begin
        wr_strobes++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end
      if (!noack) begin
        pend = lat_cfg;
        pend_we = mem_we;
      end
    end
  end
  always @(negedge clk) if (cpu_done === 1'b1) begin
    done_cnt++;
    done_cyc = cyc;
    done_rdata = cpu_rdata;
    done_err = cpu_err;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_req(input logic we, input logic [20:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int lat, input bit na);
    bit full, zero, rmw, ok, seen;
    int exp_lat, exp_rd, exp_wr, rs0, ws0, d0, a_cyc;
    logic [31:0] exp_w;
    full = we && be == 4'hf;
    zero = we && be == 4'h0;
    rmw = we && !full && !zero;
    ok = zero || !na;
    exp_w = merge(ref_rd(a), wd, be);
    exp_lat = zero ? 1 : !ok ? T + 2 : rmw ? 2 * lat + 4 : lat + 2;
    exp_rd = (!we || rmw) ? 1 : 0;
    exp_wr = (full || (rmw && ok)) ? 1 : 0;
    lat_cfg = lat;
    noack = na;
    rs0 = rd_strobes;
    ws0 = wr_strobes;
    d0 = done_cnt;
    @(negedge clk);
    a_cyc = cyc;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_be = be;
    cpu_wdata = wd;
    seen = 0;
    // Keep presenting junk requests while busy; they must all be ignored.
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) seen = 1;
      else begin
        cpu_we = 1'($urandom);
        cpu_addr = 21'($urandom);
        cpu_be = 4'($urandom);
        cpu_wdata = $urandom;
      end
    end
    cpu_req = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(done_cyc - a_cyc), 32'(exp_lat));
    chk("err", 32'(done_err), 32'(!ok));
    if (!we || !ok) chk("rdata", done_rdata, (!we && ok) ? ref_rd(a) : 32'h0);
    chk("rd_strobes", 32'(rd_strobes - rs0), 32'(exp_rd));
    chk("wr_strobes", 32'(wr_strobes - ws0), 32'(exp_wr));
    if (exp_wr == 1 && ok) begin
      chk("wr_data", wr_data, exp_w);
      chk("wr_addr", 32'(wr_addr), 32'(a));
    end
    if (ok && !zero) chk("ack_addr", 32'(ack_addr), 32'(a));
    if (ok && we && !zero) ref_mem[a] = exp_w;
    chk("mem_word", dev_rd(a), ref_rd(a));
    @(negedge clk);
    #1;
    chk("busy_after", 32'(cpu_busy), 32'd0);
    chk("single_done", 32'(done_cnt - d0), 32'd1);
    noack = 0;
  endtask
  initial begin
    int rs0, d0;
    repeat (2) @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    #1;
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_flags", 32'({cpu_done, cpu_err, cpu_busy, mem_en, mem_re, mem_we}), 32'h0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("stray_done", 32'(done_cnt), 32'd0);
    chk("stray_strobes", 32'(rd_strobes + wr_strobes), 32'd0);
    chk("stray_busy", 32'(cpu_busy), 32'd0);
    mem[21'h000010] = 32'hDEADBEEF;
    ref_mem[21'h000010] = 32'hDEADBEEF;
    do_req(1'b0, 21'h000010, 4'h0, 32'h0, 4, 0);
    chk("read_value", done_rdata, 32'hDEADBEEF);
    do_req(1'b1, 21'h100020, 4'hf, 32'h12345678, 4, 0);
    chk("full_write_value", wr_data, 32'h12345678);
    mem[21'h000030] = 32'h11223344;
    ref_mem[21'h000030] = 32'h11223344;
    do_req(1'b1, 21'h000030, 4'b0101, 32'hAABBCCDD, 4, 0);
    chk("rmw_value", wr_data, 32'h11BB33DD);
    do_req(1'b0, 21'h000040, 4'h0, 32'h0, 4, 1);
    do_req(1'b0, 21'h000040, 4'h0, 32'h0, T, 0);
    do_req(1'b1, 21'h000044, 4'b0011, 32'hCAFEF00D, 3, 1);
    // Reset while waiting for a read ack, then deliver the ack late.
    noack = 1;
    rs0 = rd_strobes;
    d0 = done_cnt;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 21'h000050;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(cpu_busy), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'h0);
    chk("midrst_strobe", 32'(rd_strobes - rs0), 32'd1);
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_no_strobe", 32'(rd_strobes - rs0 + wr_strobes), 32'd1 + 32'(wr_strobes));
    noack = 0;
    do_req(1'b1, 21'h000060, 4'h0, 32'h55555555, 4, 0);
    for (int n = 0; n < 40; n++) begin
      logic [3:0] be;
      int r;
      r = $urandom_range(0, 3);
      be = r == 0 ? 4'hf : r == 1 ? 4'h0 : 4'($urandom);
      do_req(1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), 16'h0, 4'($urandom_range(0, 15))},
             be, $urandom, $urandom_range(1, T), $urandom_range(0, 7) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: observed no end of test, required end within 50000 cycles");
    $fatal(1);
  end
endmodule
